interleave_merge: RTL

Downstream merge stage of the interleaved sync FIFO. It consumes the out_* streams of NUM_LANES parallel sync_2t_fifo lanes, which an upstream dispatcher fills in strict round-robin order. It re-serialises them into one stream in the original order. Output is fully registered through a 2-entry skid buffer, so no combinational path exists from out_ready to lane_ready.

---
 rtl/interleave_pkg.sv | 16 +
 rtl/skid_buffer_2.sv | 66 ++++++
 rtl/interleave_merge.sv | 80 ++++++++
 3 files changed

// File: rtl/interleave_pkg.sv
// interleave_pkg
// Shared constants and helpers for the interleaved FIFO merge stage.
//   SKID_DEPTH : number of output skid buffer entries
//   lane_next  : round-robin lane increment that wraps at any lane count
package interleave_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  // Wraps explicitly at num_lanes-1 so non-power-of-2 lane counts never
  // reach an out-of-range index.
  function automatic int unsigned lane_next(input int unsigned ptr,
                                            input int unsigned num_lanes);
    return (ptr == num_lanes - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// skid_buffer_2
// Two-entry registered output buffer. in_ready depends only on registered
// occupancy, so there is no combinational path from out_ready to in_ready.
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   clear         : synchronous flush, same effect as reset
//   in_data/in_valid/in_ready    : upstream valid/ready interface
//   out_data/out_valid/out_ready : downstream valid/ready interface
//   count         : occupancy, 0..2
module skid_buffer_2
  import interleave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            count
);

  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic                  w_flush;
  logic                  w_push;
  logic                  w_pop;

  assign w_flush   = !rstn || clear;
  assign in_ready  = (r_count < 2'(SKID_DEPTH)) && !w_flush;
  assign out_valid = (r_count != '0);
  assign out_data  = r_head;
  assign count     = r_count;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Data registers are deliberately left unreset: out_data holds its last
  // value through a flush and is don't-care while out_valid is low.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= in_data;
          else                 r_tail <= in_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        // Push with pop only happens at count 1 (push is blocked when full),
        // so the incoming word simply replaces the departing head.
        2'b11:   r_head <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/interleave_merge.sv
// interleave_merge
// Re-serialises NUM_LANES round-robin-filled FIFO lanes into one ordered
// stream through a registered 2-entry skid buffer.
// Ports:
//   clk, rstn   : clock, synchronous active-low reset
//   clear       : synchronous flush, restarts at lane 0
//   lane_data   : lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   lane_valid  : per-lane valid
//   lane_ready  : per-lane ready, one-hot on lane_ptr or all zero
//   out_data/out_valid/out_ready : merged output stream
//   lane_ptr    : lane expected next
//   count       : skid buffer occupancy, 0..2
module interleave_merge
  import interleave_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = 8,
  parameter  int unsigned NUM_LANES    = 2,
  localparam int unsigned LB_NUM_LANES = $clog2(NUM_LANES)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
  input  logic [NUM_LANES-1:0]            lane_valid,
  output logic [NUM_LANES-1:0]            lane_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            clear,
  output logic [LB_NUM_LANES-1:0]         lane_ptr,
  output logic [1:0]                      count
);

  logic [LB_NUM_LANES-1:0] r_ptr;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_sel_valid;
  logic                    w_in_ready;
  logic                    w_accept;

  // Only the lane under the pointer is ever looked at; other lanes stall
  // even when valid, which preserves the original word order.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    lane_ready  = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (r_ptr == LB_NUM_LANES'(i)) begin
        w_sel_data    = lane_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_valid   = lane_valid[i];
        lane_ready[i] = w_in_ready;
      end
    end
  end

  assign w_accept = w_sel_valid && w_in_ready;
  assign lane_ptr = r_ptr;

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= LB_NUM_LANES'(lane_next(32'(r_ptr), NUM_LANES));
    end
  end

  skid_buffer_2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear),
    .in_data  (w_sel_data),
    .in_valid (w_sel_valid),
    .in_ready (w_in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

endmodule
